// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation countdown timer and its prescaler.
package irrigation_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_SPRK = 1'b0;
    localparam logic MODE_DRIP = 1'b1;

    localparam int MIN_W  = 4;
    localparam int SECT_W = 3;
    localparam int SECU_W = 4;

endpackage

// File: rtl/irrigation_timer_tick_gen_1hz.sv
// Prescaler producing a one-cycle tick every CLK_HZ enabled cycles.
module tick_gen_1hz #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count holds its value while disabled so a paused run resumes mid-second.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == TC);

endmodule

// File: rtl/irrigation_timer.sv
// BCD mm:ss irrigation countdown with per-mode presets, abort and error handling.
// Define IRRIGATION_HOLD_ON_ERROR_EN to pause on error instead of cancelling.
module irrigation_timer
    import irrigation_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SPRK_MIN = 1,
    parameter int SPRK_SEC = 30,
    parameter int DRIP_MIN = 5,
    parameter int DRIP_SEC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              error,
    output logic              T,
    output logic              done,
    output logic              busy,
    output logic [MIN_W-1:0]  min_bcd,
    output logic [SECT_W-1:0] sec_t,
    output logic [SECU_W-1:0] sec_u
);

    localparam logic [MIN_W-1:0]  SPRK_M = MIN_W'(SPRK_MIN);
    localparam logic [SECT_W-1:0] SPRK_T = SECT_W'(SPRK_SEC / 10);
    localparam logic [SECU_W-1:0] SPRK_U = SECU_W'(SPRK_SEC % 10);
    localparam logic [MIN_W-1:0]  DRIP_M = MIN_W'(DRIP_MIN);
    localparam logic [SECT_W-1:0] DRIP_T = SECT_W'(DRIP_SEC / 10);
    localparam logic [SECU_W-1:0] DRIP_U = SECU_W'(DRIP_SEC % 10);

    state_t             state_q, state_d;
    logic               start_q;
    logic [MIN_W-1:0]   min_q, min_d;
    logic [SECT_W-1:0]  sect_q, sect_d;
    logic [SECU_W-1:0]  secu_q, secu_d;
    logic               tick;
    logic               startEdge;
    logic               isZero;
    logic               isOne;

    tick_gen_1hz #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .en   (state_q == RUN),
        .tick (tick)
    );

    assign startEdge = start && !start_q;
    assign isZero    = (min_q == '0) && (sect_q == '0) && (secu_q == '0);
    assign isOne     = (min_q == '0) && (sect_q == '0) && (secu_q == SECU_W'(1));

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sect_d  = sect_q;
        secu_d  = secu_q;
        case (state_q)
            IDLE: begin
                if (startEdge && !abort) begin
                    state_d = RUN;
                    if (mode == MODE_DRIP) begin
                        min_d  = DRIP_M;
                        sect_d = DRIP_T;
                        secu_d = DRIP_U;
                    end else begin
                        min_d  = SPRK_M;
                        sect_d = SPRK_T;
                        secu_d = SPRK_U;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    min_d   = '0;
                    sect_d  = '0;
                    secu_d  = '0;
                end else if (error) begin
`ifdef IRRIGATION_HOLD_ON_ERROR_EN
                    state_d = HOLD;
`else
                    state_d = IDLE;
                    min_d   = '0;
                    sect_d  = '0;
                    secu_d  = '0;
`endif
                end else if (isZero) begin
                    // A zero preset finishes without waiting for a tick.
                    state_d = DONE;
                end else if (tick) begin
                    if (isOne) begin
                        state_d = DONE;
                    end
                    if (secu_q != '0) begin
                        secu_d = secu_q - SECU_W'(1);
                    end else begin
                        secu_d = SECU_W'(9);
                        if (sect_q != '0) begin
                            sect_d = sect_q - SECT_W'(1);
                        end else begin
                            sect_d = SECT_W'(5);
                            min_d  = min_q - MIN_W'(1);
                        end
                    end
                end
            end
`ifdef IRRIGATION_HOLD_ON_ERROR_EN
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    min_d   = '0;
                    sect_d  = '0;
                    secu_d  = '0;
                end else if (!error) begin
                    state_d = RUN;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            min_q   <= '0;
            sect_q  <= '0;
            secu_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            min_q   <= min_d;
            sect_q  <= sect_d;
            secu_q  <= secu_d;
        end
    end

    assign T       = (state_q == RUN);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign min_bcd = min_q;
    assign sec_t   = sect_q;
    assign sec_u   = secu_q;

endmodule
